ex_div_unit: RTL and testbench

// - Multi-cycle 32-bit DIV/DIVU engine in the EX stage; the requester side of the pipeline stall protocol.
// - Raises stall_req (drives the controller's request_from_ex) while dividing.
// - Obeys stall_ex and flush coming back from the pipeline controller.
// - Delivers quotient (LO) and remainder (HI) to the EX result path for one accepted cycle.

---
 rtl/ex_div_unit_pkg.sv | 30 +++
 rtl/ex_div_unit_if.sv | 41 ++++
 rtl/ex_div_unit_div_step.sv | 37 +++
 rtl/ex_div_unit.sv | 125 ++++++++++++
 tb/tb_ex_div_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_div_unit_pkg
// Shared types and constants for the EX-stage DIV/DIVU engine.
//   DATA_WIDTH   operand/result width; one restoring step per bit
//   CNT_W        width of the CALC step counter
//   data_t       operand/result word
//   cnt_t        step counter
//   div_state_e  divider FSM state (IDLE / CALC / DONE)
//   abs_val()    magnitude of a word, two's complement only when is_signed
// ---------------------------------------------------------------------------
package ex_div_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = $clog2(DATA_WIDTH);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CNT_W-1:0]      cnt_t;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_DONE = 2'd2
  } div_state_e;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic data_t abs_val(input data_t x, input logic is_signed);
    return (is_signed && x[DATA_WIDTH-1]) ? data_t'(-x) : x;
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// ---------------------------------------------------------------------------
// ex_div_unit_if
// Connection between the EX stage / pipeline controller (master) and the
// divider (slave).
//   start, signed_div, op_a, op_b   instruction held in EX
//   stall_ex, flush                 controller commands back to EX
//   stall_req                       divider asks the controller to stall
//   result_valid, quotient, remainder  LO/HI results
//
// Handshake: while start is high and the divider is not finished, stall_req
// is high and the instruction must stay in EX. The cycle result_valid is
// high with stall_ex low is the accept cycle: quotient/remainder are consumed
// and the instruction leaves EX at the following edge. While stall_ex is high
// result_valid and the results hold. flush cancels everything in the same
// cycle (stall_req and result_valid drop to 0).
// ---------------------------------------------------------------------------
interface ex_div_unit_if;
  import ex_div_unit_pkg::*;

  logic  start;
  logic  signed_div;
  data_t op_a;
  data_t op_b;
  logic  stall_ex;
  logic  flush;
  logic  stall_req;
  logic  result_valid;
  data_t quotient;
  data_t remainder;

  modport master (
    output start, signed_div, op_a, op_b, stall_ex, flush,
    input  stall_req, result_valid, quotient, remainder
  );

  modport slave (
    input  start, signed_div, op_a, op_b, stall_ex, flush,
    output stall_req, result_valid, quotient, remainder
  );

endinterface

// File: rtl/ex_div_unit_div_step.sv
// ---------------------------------------------------------------------------
// ex_div_unit_div_step
// One combinational restoring-division step on magnitudes.
//   i_rem      partial remainder (always < i_divisor when i_divisor != 0)
//   i_quo      remaining dividend bits in the MSBs, quotient bits in the LSBs
//   i_divisor  divisor magnitude
//   o_rem      next partial remainder
//   o_quo      i_quo shifted left with the new quotient bit appended
// ---------------------------------------------------------------------------
module ex_div_unit_div_step
  import ex_div_unit_pkg::*;
(
  input  data_t i_rem,
  input  data_t i_quo,
  input  data_t i_divisor,
  output data_t o_rem,
  output data_t o_quo
);

  // One extra bit: the shifted remainder can exceed DATA_WIDTH bits, and the
  // top bit of the difference is the borrow that decides the quotient bit.
  logic [DATA_WIDTH:0] w_shift;
  logic [DATA_WIDTH:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_quo[DATA_WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_divisor};
    if (!w_diff[DATA_WIDTH]) begin
      o_rem = w_diff[DATA_WIDTH-1:0];
      o_quo = {i_quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[DATA_WIDTH-1:0];
      o_quo = {i_quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// ---------------------------------------------------------------------------
// ex_div_unit
// Multi-cycle DIV/DIVU engine in the EX stage. Requests a pipeline stall
// while dividing, obeys stall_ex/flush from the controller and presents
// quotient (LO) and remainder (HI) while in DONE.
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   bus          ex_div_unit_if.slave (operands, controller commands, results)
//   o_dbg_state  current FSM state
// Optional feature macro: DIV_EARLY_OUT_EN -- divide by zero or |a| < |b|
// goes IDLE -> DONE directly (one cycle of stall_req instead of 33).
// ---------------------------------------------------------------------------
module ex_div_unit
  import ex_div_unit_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  ex_div_unit_if.slave bus,
  output div_state_e   o_dbg_state
);

  div_state_e r_state;
  div_state_e w_next_state;
  cnt_t       r_cnt;
  data_t      r_rem;
  data_t      r_quo;
  data_t      r_divisor;
  logic       r_neg_q;
  logic       r_neg_r;

  data_t      w_abs_a;
  data_t      w_abs_b;
  logic       w_accept;
  logic       w_early;
  data_t      w_step_rem;
  data_t      w_step_quo;

  assign w_abs_a  = abs_val(bus.op_a, bus.signed_div);
  assign w_abs_b  = abs_val(bus.op_b, bus.signed_div);
  assign w_accept = (r_state == DIV_STATE_IDLE) && bus.start && !bus.flush;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (bus.op_b == '0) || (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  ex_div_unit_div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= DIV_STATE_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (bus.flush) begin
      w_next_state = DIV_STATE_IDLE;
    end else begin
      case (r_state)
        DIV_STATE_IDLE: if (bus.start) w_next_state = w_early ? DIV_STATE_DONE : DIV_STATE_CALC;
        // start dropping mid-CALC means the instruction was killed upstream.
        DIV_STATE_CALC: begin
          if (!bus.start)                          w_next_state = DIV_STATE_IDLE;
          else if (r_cnt == cnt_t'(DATA_WIDTH-1))  w_next_state = DIV_STATE_DONE;
        end
        DIV_STATE_DONE: if (!bus.stall_ex) w_next_state = DIV_STATE_IDLE;
        default:        w_next_state = DIV_STATE_IDLE;
      endcase
    end
  end

  // Datapath: operands are captured only on acceptance; DONE holds everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_divisor <= w_abs_b;
      r_neg_q   <= bus.signed_div && (bus.op_a[DATA_WIDTH-1] ^ bus.op_b[DATA_WIDTH-1]);
      r_neg_r   <= bus.signed_div && bus.op_a[DATA_WIDTH-1];
      if (w_early) begin
        // Same magnitudes the full iteration would produce in these cases.
        r_rem <= w_abs_a;
        r_quo <= (bus.op_b == '0) ? '1 : '0;
      end else begin
        r_rem <= '0;
        r_quo <= w_abs_a;
      end
    end else if (r_state == DIV_STATE_CALC) begin
      r_rem <= w_step_rem;
      r_quo <= w_step_quo;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs. Gated by i_rst_n so a held start cannot raise stall_req in reset.
  always_comb begin
    bus.stall_req    = i_rst_n && !bus.flush &&
                       ((r_state == DIV_STATE_CALC) || ((r_state == DIV_STATE_IDLE) && bus.start));
    bus.result_valid = i_rst_n && !bus.flush && (r_state == DIV_STATE_DONE);
    bus.quotient     = '0;
    bus.remainder    = '0;
    if (bus.result_valid) begin
      bus.quotient  = r_neg_q ? data_t'(-r_quo) : r_quo;
      bus.remainder = r_neg_r ? data_t'(-r_rem) : r_rem;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_div_unit.sv
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  div_state_e dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ex_div_unit_if bus_if();

  ex_div_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];   // {quotient, remainder}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain signed/unsigned arithmetic: truncating division, remainder keeps
  // the dividend's sign; divide by zero gives (sign-corrected) all ones / op_a.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    la = sgn ? longint'($signed(a)) : longint'(a);
    lb = sgn ? longint'($signed(b)) : longint'(b);
    if (lb == 0) begin
      q = (la < 0) ? 1 : -1;
      r = la;
    end else begin
      q = la / lb;
      r = la % lb;
    end
    return {q[31:0], r[31:0]};
  endfunction

  function automatic int exp_latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb;
    la = sgn ? longint'($signed(a)) : longint'(a);
    lb = sgn ? longint'($signed(b)) : longint'(b);
    if (la < 0) la = -la;
    if (lb < 0) lb = -lb;
`ifdef DIV_EARLY_OUT_EN
    if (lb == 0 || la < lb) return 1;
`endif
    return DATA_WIDTH + 1;
  endfunction

  // ---------------- compare process ----------------
  logic [63:0] cur;
  logic        cur_ok = 1'b0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus_if.result_valid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          cur_ok = 1'b0;
          check("unexpected_result_valid", 64'(bus_if.result_valid), 64'd0);
        end else begin
          cur    = exp_q.pop_front();
          cur_ok = 1'b1;
        end
      end
      if (cur_ok) begin
        check("quotient",  64'(bus_if.quotient),  64'(cur[63:32]));
        check("remainder", 64'(bus_if.remainder), 64'(cur[31:0]));
      end
    end
    prev_valid = bus_if.result_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_slot();
    @(posedge clk); #1;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hq, input logic [31:0] hr);
    logic [63:0] m;
    int lat, sr_cnt;
    bit seen;
    m = model(sgn, a, b);
    check("model_q", 64'(m[63:32]), 64'(hq));
    check("model_r", 64'(m[31:0]),  64'(hr));
    lat = exp_latency(sgn, a, b);
    exp_q.push_back(m);
    drive_slot();
    bus_if.start = 1'b1; bus_if.signed_div = sgn; bus_if.op_a = a; bus_if.op_b = b;
    seen = 0; sr_cnt = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (bus_if.result_valid) begin
        seen = 1;
        check("latency", 64'(t), 64'(lat));
        check("stall_req_in_done", 64'(bus_if.stall_req), 64'd0);
      end else begin
        if (bus_if.stall_req) sr_cnt++;
        drive_slot();
        // Operands must be ignored once the division has started.
        bus_if.op_a = $urandom; bus_if.op_b = $urandom;
        bus_if.signed_div = 1'($urandom_range(0, 1));
      end
    end
    check("valid_seen", 64'(seen), 64'd1);
    check("stall_req_cycles", 64'(sr_cnt), 64'(lat));
    drive_slot();
    bus_if.start = 1'b0;
    @(negedge clk);
    check("idle_after_accept", 64'(dbg_state), 64'(DIV_STATE_IDLE));
    check("no_valid_after_accept", 64'(bus_if.result_valid), 64'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    bus_if.start = 1'b0; bus_if.signed_div = 1'b0;
    bus_if.op_a = '0; bus_if.op_b = '0;
    bus_if.stall_ex = 1'b0; bus_if.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state",     64'(dbg_state), 64'(DIV_STATE_IDLE));
    check("rst_stall_req", 64'(bus_if.stall_req), 64'd0);
    check("rst_valid",     64'(bus_if.result_valid), 64'd0);
    check("rst_quotient",  64'(bus_if.quotient), 64'd0);
    check("rst_remainder", 64'(bus_if.remainder), 64'd0);
    drive_slot();
    rst_n = 1'b1;

    run_div(1'b0, 32'd100,        32'd7,        32'd14,       32'd2);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_div(1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5);
    run_div(1'b0, 32'd3,          32'd9,        32'd0,        32'd3);
    run_div(1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
    run_div(1'b1, 32'd7,          32'd0,        32'hFFFFFFFF, 32'd7);
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0);
    run_div(1'b0, 32'hFFFFFFFE,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE);

    // flush at T10: dead in the same cycle, IDLE at T11, restart at T12.
    drive_slot();
    bus_if.start = 1'b1; bus_if.signed_div = 1'b0; bus_if.op_a = 32'd1000; bus_if.op_b = 32'd3;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      drive_slot();
    end
    bus_if.flush = 1'b1;
    @(negedge clk);
    check("flush_stall_req", 64'(bus_if.stall_req), 64'd0);
    check("flush_valid",     64'(bus_if.result_valid), 64'd0);
    drive_slot();
    bus_if.flush = 1'b0; bus_if.start = 1'b0;
    @(negedge clk);
    check("flush_idle",      64'(dbg_state), 64'(DIV_STATE_IDLE));
    check("flush_sr_t11",    64'(bus_if.stall_req), 64'd0);
    run_div(1'b0, 32'd77, 32'd5, 32'd15, 32'd2);

    // stall_ex held T33..T36: results held, IDLE at T38, no restart.
    exp_q.push_back(model(1'b0, 32'd100, 32'd7));
    drive_slot();
    bus_if.start = 1'b1; bus_if.signed_div = 1'b0; bus_if.op_a = 32'd100; bus_if.op_b = 32'd7;
    for (int t = 0; t < 33; t++) begin
      @(negedge clk);
      drive_slot();
      if (t == 32) bus_if.stall_ex = 1'b1;
    end
    for (int t = 33; t <= 36; t++) begin
      @(negedge clk);
      check("hold_valid",     64'(bus_if.result_valid), 64'd1);
      check("hold_state",     64'(dbg_state), 64'(DIV_STATE_DONE));
      check("hold_stall_req", 64'(bus_if.stall_req), 64'd0);
      drive_slot();
      if (t == 36) bus_if.stall_ex = 1'b0;
    end
    @(negedge clk);
    check("accept_valid_t37", 64'(bus_if.result_valid), 64'd1);
    drive_slot();
    bus_if.start = 1'b0;
    @(negedge clk);
    check("idle_t38",  64'(dbg_state), 64'(DIV_STATE_IDLE));
    check("valid_t38", 64'(bus_if.result_valid), 64'd0);

    // asynchronous reset mid-CALC (T5)
    drive_slot();
    bus_if.start = 1'b1; bus_if.signed_div = 1'b0; bus_if.op_a = 32'd100; bus_if.op_b = 32'd7;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      drive_slot();
    end
    rst_n = 1'b0;
    #1;
    check("arst_state",     64'(dbg_state), 64'(DIV_STATE_IDLE));
    check("arst_stall_req", 64'(bus_if.stall_req), 64'd0);
    check("arst_valid",     64'(bus_if.result_valid), 64'd0);
    check("arst_quotient",  64'(bus_if.quotient), 64'd0);
    check("arst_remainder", 64'(bus_if.remainder), 64'd0);
    @(negedge clk);
    bus_if.start = 1'b0;
    drive_slot();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", 64'(dbg_state), 64'(DIV_STATE_IDLE));
    check("post_rst_sr",    64'(bus_if.stall_req), 64'd0);

    run_div(1'b1, 32'hFFFFFF9C, 32'd10, 32'hFFFFFFF6, 32'd0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
